// File: rtl/gray_seq_pkg.sv
// Shared state and command encodings for the Gray-code sequencer.
package gray_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_START = 2'b01,
    OP_PAUSE = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  function automatic logic state_is_busy(input state_e st);
    return (st == ST_RUN) || (st == ST_HOLD);
  endfunction

endpackage

// File: rtl/gray_enc.sv
// Combinational binary-to-Gray converter.
module gray_enc #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] bin,
  output logic [WIDTH-1:0] gray
);

  always_comb begin
    gray = bin ^ (bin >> 1);
  end

endmodule

// File: rtl/gray_seq_ctrl.sv
// Command-driven sequencer: counts 0..limit in binary and publishes a registered Gray code.
module gray_seq_ctrl
  import gray_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_limit,
  output logic [WIDTH-1:0] gray_out,
  output logic             busy,
  output logic             done,
  output logic             cmd_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [WIDTH-1:0] gray_q, gray_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;

  logic             accept;
  op_e              op;

  assign op     = op_e'(cmd_op);
  assign accept = cmd_valid && ready_q;

  gray_enc #(.WIDTH(WIDTH)) u_gray_enc (
    .bin  (bin_d),
    .gray (gray_d)
  );

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    limit_d = limit_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    ready_d = 1'b1;

    unique case (state_q)
      ST_IDLE: begin
        if (accept) begin
          unique case (op)
            OP_LOAD:  limit_d = cmd_limit;
            OP_START: begin
              bin_d   = '0;
              state_d = ST_RUN;
            end
            OP_PAUSE: ;
            OP_CLEAR: bin_d = '0;
          endcase
        end
      end

      ST_RUN: begin
        // CLEAR beats PAUSE beats the terminal-count check; LOAD only flags an error.
        if (accept && op == OP_CLEAR) begin
          state_d = ST_IDLE;
          bin_d   = '0;
        end else if (accept && op == OP_PAUSE) begin
          state_d = ST_HOLD;
        end else if (bin_q == limit_q) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end else begin
          bin_d = bin_q + WIDTH'(1);
        end
        if (accept && op == OP_LOAD) begin
          err_d = 1'b1;
        end
      end

      ST_HOLD: begin
        if (accept) begin
          unique case (op)
            OP_LOAD:  err_d = 1'b1;
            OP_START: state_d = ST_RUN;
            OP_PAUSE: ;
            OP_CLEAR: begin
              state_d = ST_IDLE;
              bin_d   = '0;
            end
          endcase
        end
      end

      ST_DONE: begin
        if (accept) begin
          unique case (op)
            OP_LOAD:  limit_d = cmd_limit;
            OP_START: begin
              bin_d   = '0;
              state_d = ST_RUN;
            end
            OP_PAUSE: ;
            OP_CLEAR: begin
              state_d = ST_IDLE;
              bin_d   = '0;
            end
          endcase
        end
      end

      default: begin
        state_d = ST_IDLE;
        bin_d   = '0;
      end
    endcase

    busy_d = state_is_busy(state_d);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      limit_q <= '1;
      gray_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      limit_q <= limit_d;
      gray_q  <= gray_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign cmd_ready = ready_q;
  assign gray_out  = gray_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign cmd_err   = err_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Self-checking bench for gray_seq_ctrl: vector table, directed corner sequences, random vs reference model.
module tb_gray_seq_ctrl;

  localparam int W    = 4;
  localparam int MAXV = (1 << W) - 1;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_HOLD = 2;
  localparam int M_DONE = 3;

  localparam logic [1:0] C_LOAD  = 2'b00;
  localparam logic [1:0] C_START = 2'b01;
  localparam logic [1:0] C_PAUSE = 2'b10;
  localparam logic [1:0] C_CLEAR = 2'b11;

  logic         clk = 1'b0;
  logic         reset;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [1:0]   cmd_op;
  logic [W-1:0] cmd_limit;
  logic [W-1:0] gray_out;
  logic         busy;
  logic         done;
  logic         cmd_err;

  int errors = 0;
  int checks = 0;

  // Reference model state, in plain integers
  int m_st, m_bin, m_lim;
  int m_ready, m_done, m_err;

  gray_seq_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_limit (cmd_limit),
    .gray_out  (gray_out),
    .busy      (busy),
    .done      (done),
    .cmd_err   (cmd_err)
  );

  always #5 clk = ~clk;

  function automatic int to_gray(input int b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst_n, input bit v, input logic [1:0] op, input int lim);
    bit acc;
    if (!rst_n) begin
      m_st = M_IDLE; m_bin = 0; m_lim = MAXV;
      m_ready = 0; m_done = 0; m_err = 0;
      return;
    end
    acc = v && (m_ready != 0);
    m_done = 0;
    m_err  = 0;
    case (m_st)
      M_IDLE: if (acc) begin
        if (op == C_LOAD) m_lim = lim;
        else if (op == C_START) begin m_bin = 0; m_st = M_RUN; end
        else if (op == C_CLEAR) m_bin = 0;
      end
      M_RUN: begin
        if (acc && op == C_CLEAR) begin m_st = M_IDLE; m_bin = 0; end
        else if (acc && op == C_PAUSE) m_st = M_HOLD;
        else if (m_bin == m_lim) begin m_st = M_DONE; m_done = 1; end
        else m_bin = m_bin + 1;
        if (acc && op == C_LOAD) m_err = 1;
      end
      M_HOLD: if (acc) begin
        if (op == C_START) m_st = M_RUN;
        else if (op == C_CLEAR) begin m_st = M_IDLE; m_bin = 0; end
        else if (op == C_LOAD) m_err = 1;
      end
      default: if (acc) begin
        if (op == C_START) begin m_bin = 0; m_st = M_RUN; end
        else if (op == C_LOAD) m_lim = lim;
        else if (op == C_CLEAR) begin m_st = M_IDLE; m_bin = 0; end
      end
    endcase
    m_ready = 1;
  endtask

  // One clock: drive inputs, update model at the edge, sample 1 ns later and compare to model.
  task automatic step(input bit rst_n, input bit v, input logic [1:0] op, input int lim);
    reset     = rst_n;
    cmd_valid = v;
    cmd_op    = op;
    cmd_limit = W'(lim);
    @(posedge clk);
    model_edge(rst_n, v, op, lim);
    #1;
    check("model_gray",  int'(gray_out),  to_gray(m_bin));
    check("model_busy",  int'(busy),      int'(m_st == M_RUN || m_st == M_HOLD));
    check("model_done",  int'(done),      m_done);
    check("model_err",   int'(cmd_err),   m_err);
    check("model_ready", int'(cmd_ready), m_ready);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, C_LOAD, 0);
  endtask

  task automatic cmd(input logic [1:0] op, input int lim);
    step(1'b1, 1'b1, op, lim);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, C_LOAD, 0);
    step(1'b0, 1'b0, C_LOAD, 0);
  endtask

  typedef struct {
    bit         v;
    logic [1:0] op;
    int         lim;
    int         gray;
    bit         busy;
    bit         done;
    bit         err;
  } vec_t;

  vec_t vecs[9];

  initial begin
    int done_cnt;
    int prev_gray;
    int budget;

    reset = 1'b0; cmd_valid = 1'b0; cmd_op = C_LOAD; cmd_limit = '0;

    // Test 1: reset, then ready rises and outputs stay quiet
    do_reset();
    check("t1_ready_in_reset", int'(cmd_ready), 0);
    check("t1_gray_in_reset",  int'(gray_out), 0);
    for (int i = 0; i < 10; i++) begin
      idle(1);
      check("t1_ready", int'(cmd_ready), 1);
      check("t1_gray",  int'(gray_out), 0);
      check("t1_busy",  int'(busy), 0);
      check("t1_done",  int'(done), 0);
    end

    // Test 2: table-driven LOAD 5 / START run
    vecs[0] = '{1, C_LOAD,  5, 0, 0, 0, 0};
    vecs[1] = '{1, C_START, 0, 0, 1, 0, 0};
    vecs[2] = '{0, C_LOAD,  0, 1, 1, 0, 0};
    vecs[3] = '{0, C_LOAD,  0, 3, 1, 0, 0};
    vecs[4] = '{0, C_LOAD,  0, 2, 1, 0, 0};
    vecs[5] = '{0, C_LOAD,  0, 6, 1, 0, 0};
    vecs[6] = '{0, C_LOAD,  0, 7, 1, 0, 0};
    vecs[7] = '{0, C_LOAD,  0, 7, 0, 1, 0};
    vecs[8] = '{0, C_LOAD,  0, 7, 0, 0, 0};
    for (int i = 0; i < 9; i++) begin
      step(1'b1, vecs[i].v, vecs[i].op, vecs[i].lim);
      check($sformatf("t2_gray[%0d]", i), int'(gray_out), vecs[i].gray);
      check($sformatf("t2_busy[%0d]", i), int'(busy),     int'(vecs[i].busy));
      check($sformatf("t2_done[%0d]", i), int'(done),     int'(vecs[i].done));
      check($sformatf("t2_err[%0d]",  i), int'(cmd_err),  int'(vecs[i].err));
    end

    // Test 3: pause at bin 4, resume, run to 15
    cmd(C_LOAD, 15);
    cmd(C_START, 0);
    idle(4);
    check("t3_gray_bin4", int'(gray_out), 6);
    cmd(C_PAUSE, 0);
    for (int i = 0; i < 3; i++) begin
      check("t3_gray_paused", int'(gray_out), 6);
      check("t3_busy_paused", int'(busy), 1);
      if (i < 2) idle(1);
    end
    cmd(C_START, 0);
    check("t3_gray_resume_edge", int'(gray_out), 6);
    idle(1);
    check("t3_gray_resumed", int'(gray_out), 7);
    prev_gray = int'(gray_out);
    done_cnt = 0;
    budget = 0;
    while (done_cnt == 0 && budget < 40) begin
      idle(1);
      check("t3_gray_one_bit_step", int'($countones(W'(prev_gray) ^ gray_out) <= 1), 1);
      prev_gray = int'(gray_out);
      if (done) done_cnt++;
      budget++;
    end
    check("t3_done_seen", done_cnt, 1);
    check("t3_gray_at_done", int'(gray_out), 8);

    // Test 4: LOAD during RUN flags error and leaves limit alone
    cmd(C_LOAD, 6);
    cmd(C_START, 0);
    idle(2);
    cmd(C_LOAD, 2);
    check("t4_err_pulse", int'(cmd_err), 1);
    check("t4_gray_still_counting", int'(gray_out), to_gray(3));
    idle(1);
    check("t4_err_clears", int'(cmd_err), 0);
    budget = 0;
    while (!done && budget < 40) begin idle(1); budget++; end
    check("t4_done_seen", int'(done), 1);
    check("t4_gray_old_limit", int'(gray_out), to_gray(6));

    // Test 5: limit 0, then restart from DONE
    cmd(C_LOAD, 0);
    cmd(C_START, 0);
    check("t5_busy_e1", int'(busy), 1);
    check("t5_done_e1", int'(done), 0);
    idle(1);
    check("t5_done_e2", int'(done), 1);
    check("t5_gray_e2", int'(gray_out), 0);
    idle(1);
    check("t5_done_drop", int'(done), 0);
    cmd(C_START, 0);
    check("t5_restart_busy", int'(busy), 1);
    idle(1);
    check("t5_second_done", int'(done), 1);

    // Test 6: reset mid-RUN, then CLEAR mid-HOLD
    cmd(C_LOAD, 15);
    cmd(C_START, 0);
    idle(3);
    check("t6_gray_bin3", int'(gray_out), 2);
    step(1'b0, 1'b0, C_LOAD, 0);
    check("t6_rst_gray",  int'(gray_out), 0);
    check("t6_rst_busy",  int'(busy), 0);
    check("t6_rst_done",  int'(done), 0);
    check("t6_rst_ready", int'(cmd_ready), 0);
    idle(1);
    cmd(C_START, 0);
    idle(2);
    check("t6_limit_reset_max", int'(gray_out), to_gray(2));
    cmd(C_PAUSE, 0);
    cmd(C_CLEAR, 0);
    check("t6_clear_gray", int'(gray_out), 0);
    check("t6_clear_busy", int'(busy), 0);
    check("t6_clear_done", int'(done), 0);
    idle(2);
    check("t6_no_late_done", int'(done), 0);

    // Random phase against the reference model
    for (int i = 0; i < 1500; i++) begin
      bit rn;
      rn = ($urandom_range(0, 99) != 0);
      step(rn, 1'($urandom_range(0, 2) == 0), 2'($urandom), int'($urandom_range(0, MAXV)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule
